muldiv_sequencer: RTL and testbench

- Multi-cycle controller for MIPS MULT/MULTU/DIV/DIVU and the architectural HI/LO registers.
- Sits beside the EX-stage ALU. Accepts an operation from EX, runs a 32-iteration shift-add multiply or restoring divide, then applies sign correction and commits the result to HI/LO.
- Drives a stall request to the hazard logic while any HI/LO consumer or new mul/div reaches EX before the result is ready.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_core.sv | 63 ++++++
 rtl/muldiv_sequencer.sv | 149 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;
    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

    // Even encodings are the signed variants.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction
endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one adder.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    logic [WIDTH-1:0] r_hi, r_lo, r_b;
    logic [WIDTH:0]   w_opa, w_opb, w_sum;
    logic             w_cin;

    // Divide: trial-subtract the divisor from {rem, next dividend bit}.
    // Multiply: conditionally add the multiplicand into the upper half.
    always_comb begin
        if (i_is_div) begin
            w_opa = {r_hi, r_lo[WIDTH-1]};
            w_opb = ~{1'b0, r_b};
            w_cin = 1'b1;
        end else begin
            w_opa = {1'b0, r_hi};
            w_opb = r_lo[0] ? {1'b0, r_b} : '0;
            w_cin = 1'b0;
        end
        w_sum = w_opa + w_opb + {{WIDTH{1'b0}}, w_cin};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (i_load) begin
            r_hi <= '0;
            r_lo <= i_a;
            r_b  <= i_b;
        end else if (i_step) begin
            if (i_is_div) begin
                if (w_sum[WIDTH]) begin
                    r_hi <= w_opa[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                end else begin
                    r_hi <= w_sum[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                end
            end else begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;
endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU controller with architectural HI/LO and EX-stage stall request.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Abort,
    input  logic             HiLoRead,
    input  logic             MTHI,
    input  logic             MTLO,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    state_e           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_a, r_neg_b, r_is_div, r_dbz;
    logic [WIDTH-1:0] r_raw_a, r_hi, r_lo;

    logic             w_load, w_step, w_commit, w_busy;
    logic             w_neg_a, w_neg_b;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic [WIDTH-1:0] w_core_hi, w_core_lo, w_res_hi, w_res_lo;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;

    assign w_neg_a = op_is_signed(Op) & SrcA[WIDTH-1];
    assign w_neg_b = op_is_signed(Op) & SrcB[WIDTH-1];
    assign w_mag_a = w_neg_a ? -SrcA : SrcA;
    assign w_mag_b = w_neg_b ? -SrcB : SrcB;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Start && !Abort) w_next = RUN;
            RUN:     if (Abort) w_next = IDLE;
                     else if (r_cnt == CNT_W'(WIDTH-1)) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy   = 1'b0;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            IDLE: w_load = Start & ~Abort;
            RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
            end
            FIX: begin
                w_busy   = 1'b1;
                w_commit = ~Abort;
            end
            default: ;
        endcase
    end

    assign Busy  = w_busy;
    assign Done  = w_commit;
    assign Stall = w_busy & (Start | HiLoRead | MTHI | MTLO);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_is_div <= 1'b0;
            r_dbz    <= 1'b0;
            r_raw_a  <= '0;
        end else if (w_load) begin
            r_cnt    <= '0;
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_is_div <= Op[1];
            r_dbz    <= Op[1] & (SrcB == '0);
            r_raw_a  <= SrcA;
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_is_div (r_is_div),
        .i_a      (w_mag_a),
        .i_b      (w_mag_b),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

    assign w_prod = {w_core_hi, w_core_lo};

    // Remainder follows the dividend's sign; divide-by-zero bypasses correction.
    always_comb begin
        w_res_hi   = w_core_hi;
        w_res_lo   = w_core_lo;
        w_prod_fix = w_prod;
        if (r_dbz) begin
            w_res_hi = r_raw_a;
            w_res_lo = '1;
        end else if (r_is_div) begin
            if (r_neg_a ^ r_neg_b) w_res_lo = -w_core_lo;
            if (r_neg_a)           w_res_hi = -w_core_hi;
        end else begin
            if (r_neg_a ^ r_neg_b) w_prod_fix = -w_prod;
            {w_res_hi, w_res_lo} = w_prod_fix;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (r_state == IDLE && !Start) begin
            if (MTHI) r_hi <= WrData;
            if (MTLO) r_lo <= WrData;
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

    // A mul/div issuing alongside an MT write would silently drop the write.
    a_no_start_with_mt: assert property (@(posedge CLK) disable iff (RST)
        !(r_state == IDLE && Start && (MTHI || MTLO)));
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized checks of muldiv_sequencer against an arithmetic reference.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;
    localparam int W = 32;

    logic         CLK = 1'b0, RST = 1'b1, Start = 1'b0, Abort = 1'b0;
    logic         HiLoRead = 1'b0, MTHI = 1'b0, MTLO = 1'b0;
    logic [1:0]   Op = 2'b00;
    logic [W-1:0] SrcA = '0, SrcB = '0, WrData = '0;
    logic         Busy, Stall, Done;
    logic [W-1:0] HI, LO;
    int           tests = 0, fails = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
        .Abort(Abort), .HiLoRead(HiLoRead), .MTHI(MTHI), .MTLO(MTLO), .WrData(WrData),
        .Busy(Busy), .Stall(Stall), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            2'b10: begin
                if (b == '0) begin hi = a; lo = '1; end
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            default: begin
                if (b == '0) begin hi = a; lo = '1; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Caller has Start asserted; edge 0 accepts it, result is visible after edge 33.
    task automatic run_body(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
        int bad;
        bad = 0;
        tick();
        Start = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            if (Busy !== 1'b1 || Done !== (k == 32)) bad++;
            tick();
        end
        chk({tag, " latency"}, W'(bad), '0);
        chk({tag, " busy"}, W'(Busy), '0);
        chk({tag, " hi"}, HI, eh);
        chk({tag, " lo"}, LO, el);
    endtask

    task automatic launch(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eh, el;
        model(op, a, b, eh, el);
        Start = 1'b1;
        Op    = op;
        SrcA  = a;
        SrcB  = b;
        run_body(tag, eh, el);
    endtask

    initial begin
        logic [W-1:0] eh, el, a, b;
        int bad;

        tick();
        chk("reset hi", HI, '0);
        chk("reset lo", LO, '0);
        chk("reset busy", W'(Busy), '0);
        chk("reset stall", W'(Stall), '0);
        chk("reset done", W'(Done), '0);
        RST = 1'b0;
        tick();

        launch("mult 3*-4", OP_MULT, 32'd3, 32'hFFFFFFFC);
        chk("mult 3*-4 hi const", HI, 32'hFFFFFFFF);
        chk("mult 3*-4 lo const", LO, 32'hFFFFFFF4);
        launch("divu 100/7", OP_DIVU, 32'd100, 32'd7);
        chk("divu lo const", LO, 32'd14);
        chk("divu hi const", HI, 32'd2);
        launch("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2);
        chk("div -7/2 lo const", LO, 32'hFFFFFFFD);
        chk("div -7/2 hi const", HI, 32'hFFFFFFFF);
        launch("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("div min/-1 lo const", LO, 32'h80000000);
        chk("div min/-1 hi const", HI, 32'h0);
        launch("div by 0", OP_DIV, 32'h1234, 32'h0);
        chk("div by 0 lo const", LO, 32'hFFFFFFFF);
        chk("div by 0 hi const", HI, 32'h1234);
        launch("div -5/0", OP_DIV, 32'hFFFFFFFB, 32'h0);
        launch("mult min*min", OP_MULT, 32'h80000000, 32'h80000000);
        launch("multu max*max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);

        for (int i = 0; i < 40; i++) begin
            a = pick();
            b = pick();
            launch("random", 2'($urandom_range(0, 3)), a, b);
        end

        // HiLoRead and a second Start held while busy.
        a = 32'($urandom);
        b = 32'($urandom);
        model(OP_MULTU, a, b, eh, el);
        Start = 1'b1; Op = OP_MULTU; SrcA = a; SrcB = b;
        tick();
        Start = 1'b0;
        bad = 0;
        a = 32'd1000 + 32'($urandom_range(0, 999));
        b = 32'd3 + 32'($urandom_range(0, 9));
        for (int k = 0; k <= 32; k++) begin
            if (k >= 4) begin
                HiLoRead = 1'b1; Start = 1'b1; Op = OP_DIVU; SrcA = a; SrcB = b;
            end
            #1;
            if (Stall !== (k >= 4)) bad++;
            tick();
        end
        chk("stall window", W'(bad), '0);
        chk("stall drops", W'(Stall), '0);
        chk("stall op hi", HI, eh);
        chk("stall op lo", LO, el);
        HiLoRead = 1'b0;
        model(OP_DIVU, a, b, eh, el);
        run_body("held start", eh, el);

        // MT writes in IDLE.
        WrData = 32'h55; MTLO = 1'b1;
        tick();
        MTLO = 1'b0;
        chk("mtlo", LO, 32'h55);
        WrData = 32'hA; MTHI = 1'b1;
        tick();
        MTHI = 1'b0; WrData = 32'hB; MTLO = 1'b1;
        tick();
        MTLO = 1'b0;
        chk("mthi", HI, 32'hA);
        chk("mtlo b", LO, 32'hB);

        // Abort during RUN at edge 10.
        Start = 1'b1; Op = OP_MULT; SrcA = 32'd7; SrcB = 32'd9;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("abort run idle", W'(Busy), '0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (Done !== 1'b0) bad++;
            tick();
        end
        chk("abort run no done", W'(bad), '0);
        chk("abort run hi", HI, 32'hA);
        chk("abort run lo", LO, 32'hB);

        // Abort landing on the FIX cycle.
        Start = 1'b1; Op = OP_DIVU; SrcA = 32'd50; SrcB = 32'd5;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 32; k++) tick();
        chk("fix done", W'(Done), 32'd1);
        Abort = 1'b1;
        #1;
        chk("fix abort done", W'(Done), '0);
        tick();
        Abort = 1'b0;
        chk("fix abort busy", W'(Busy), '0);
        chk("fix abort hi", HI, 32'hA);
        chk("fix abort lo", LO, 32'hB);

        // Start with Abort in IDLE.
        Start = 1'b1; Abort = 1'b1;
        tick();
        Start = 1'b0; Abort = 1'b0;
        chk("start+abort", W'(Busy), '0);

        // MTHI held while busy.
        a = 32'($urandom);
        b = 32'($urandom);
        model(OP_MULTU, a, b, eh, el);
        Start = 1'b1; Op = OP_MULTU; SrcA = a; SrcB = b;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        MTHI = 1'b1; WrData = 32'h77;
        #1;
        chk("mthi busy stall", W'(Stall), 32'd1);
        bad = 0;
        for (int k = 0; k < 29; k++) begin
            tick();
            if (HI !== 32'hA) bad++;
        end
        chk("mthi busy hi held", W'(bad), '0);
        tick();
        chk("mthi op hi", HI, eh);
        chk("mthi op lo", LO, el);
        tick();
        MTHI = 1'b0;
        chk("mthi after op", HI, 32'h77);
        chk("mthi after op lo", LO, el);

        // Reset at edge 20 of a DIV.
        Start = 1'b1; Op = OP_DIV; SrcA = 32'hFFFF0000; SrcB = 32'd3;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 19; k++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("midop rst busy", W'(Busy), '0);
        chk("midop rst hi", HI, '0);
        chk("midop rst lo", LO, '0);
        launch("post reset div", OP_DIV, 32'hFFFF0000, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
